// File: rtl/vic_regbank_dbuf_if.sv
// Host-side bus of the double-buffered VIC register bank.
// Carries register access, frame sync and the active-bank outputs.
interface vic_regbank_dbuf_if #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]           i_VIC_regaddr;
  logic [DATA_W-1:0]           i_VIC_data;
  logic                        i_VIC_we;
  logic [DATA_W-1:0]           o_VIC_data;
  logic                        i_frame_sync;
  logic [(NREGS-1)*DATA_W-1:0] o_buffer;
  logic                        o_enable;
  logic                        o_commit_pending;
  logic                        o_commit_done;

  modport master (
    output i_VIC_regaddr,
    output i_VIC_data,
    output i_VIC_we,
    output i_frame_sync,
    input  o_VIC_data,
    input  o_buffer,
    input  o_enable,
    input  o_commit_pending,
    input  o_commit_done
  );

  modport slave (
    input  i_VIC_regaddr,
    input  i_VIC_data,
    input  i_VIC_we,
    input  i_frame_sync,
    output o_VIC_data,
    output o_buffer,
    output o_enable,
    output o_commit_pending,
    output o_commit_done
  );
endinterface

// File: rtl/vic_regbank_dbuf.sv
// Double-buffered VIC register bank: host writes hit a shadow bank,
// the active bank takes a whole-bank copy on commit.
module vic_regbank_dbuf #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  vic_regbank_dbuf_if.slave bus
);
  localparam int NDATA = NREGS - 1;
  localparam int BUF_W = NDATA * DATA_W;
  localparam int IDX_W = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NDATA);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SYNC = 2'd1;
  localparam logic [1:0] COPY      = 2'd2;

  logic [DATA_W-1:0] shadow [NDATA];
  logic [BUF_W-1:0]  active;
  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              en_q;
  logic              imm_q;
  logic              req_q;
  logic              req_imm_q;
  logic              pend_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ctrl_rd;
  logic [IDX_W-1:0]  idx;
  logic              is_data;
  logic              is_ctrl;
  logic              data_wr;
  logic              ctrl_wr;
  logic              commit_req;

  assign idx     = bus.i_VIC_regaddr[IDX_W-1:0];
  assign is_data = bus.i_VIC_regaddr < CTRL_ADDR;
  assign is_ctrl = bus.i_VIC_regaddr == CTRL_ADDR;
  assign data_wr = bus.i_VIC_we && is_data;
  assign ctrl_wr = bus.i_VIC_we && is_ctrl;

  // Requests are only taken from a quiet IDLE; nothing is queued.
  assign commit_req = ctrl_wr && bus.i_VIC_data[1]
                   && state == IDLE && !req_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_q)
          state_nx = req_imm_q ? COPY : WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (bus.i_frame_sync)
          state_nx = COPY;
      end
      COPY: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = pend_q;
    ctrl_rd[2] = imm_q;
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_data: rd_data = shadow[idx];
      is_ctrl: rd_data = ctrl_rd;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NDATA; k++)
        shadow[k] <= '0;
    end else if (data_wr) begin
      shadow[idx] <= bus.i_VIC_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      imm_q     <= 1'b0;
      req_q     <= 1'b0;
      req_imm_q <= 1'b0;
    end else begin
      req_q <= commit_req;
      if (ctrl_wr) begin
        en_q  <= bus.i_VIC_data[0];
        imm_q <= bus.i_VIC_data[2];
      end
      if (commit_req)
        req_imm_q <= bus.i_VIC_data[2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      pend_q <= state_nx == WAIT_SYNC;
      done_q <= state == COPY;
    end
  end

  // Non-blocking copy: a shadow write on this edge is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= '0;
    end else if (state == COPY) begin
      for (int k = 0; k < NDATA; k++)
        active[k*DATA_W +: DATA_W] <= shadow[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_q <= '0;
    else
      rd_q <= rd_data;
  end

  assign bus.o_VIC_data       = rd_q;
  assign bus.o_buffer         = active;
  assign bus.o_enable         = en_q;
  assign bus.o_commit_pending = pend_q;
  assign bus.o_commit_done    = done_q;

endmodule

// File: tb/tb_vic_regbank_dbuf.sv
// Directed bench for vic_regbank_dbuf: default 4x32 bank plus an
// 8-bit, 16-register build; read data checked through a queue.
module tb_vic_regbank_dbuf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  logic [127:0] sb [$];

  vic_regbank_dbuf_if #(.DATA_W(4), .NREGS(32), .ADDR_W(5)) b1();
  vic_regbank_dbuf_if #(.DATA_W(8), .NREGS(16), .ADDR_W(5)) b2();

  vic_regbank_dbuf #(.DATA_W(4), .NREGS(32), .ADDR_W(5)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  vic_regbank_dbuf #(.DATA_W(8), .NREGS(16), .ADDR_W(5)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(logic [4:0] a, logic [3:0] d);
    b1.i_VIC_regaddr = a;
    b1.i_VIC_data    = d;
    b1.i_VIC_we      = 1'b1;
    tick();
    b1.i_VIC_we      = 1'b0;
  endtask

  task automatic wr2(logic [4:0] a, logic [7:0] d);
    b2.i_VIC_regaddr = a;
    b2.i_VIC_data    = d;
    b2.i_VIC_we      = 1'b1;
    tick();
    b2.i_VIC_we      = 1'b0;
  endtask

  task automatic rd1(string tag, logic [4:0] a, logic [3:0] exp);
    b1.i_VIC_regaddr = a;
    sb.push_back(128'(exp));
    tick();
    check(tag, 128'(b1.o_VIC_data), sb.pop_front());
  endtask

  task automatic rd2(string tag, logic [4:0] a, logic [7:0] exp);
    b2.i_VIC_regaddr = a;
    sb.push_back(128'(exp));
    tick();
    check(tag, 128'(b2.o_VIC_data), sb.pop_front());
  endtask

  task automatic all_zero1(string tag);
    check({tag, "_buf"}, 128'(b1.o_buffer), 128'd0);
    check({tag, "_en"}, 128'(b1.o_enable), 128'd0);
    check({tag, "_rd"}, 128'(b1.o_VIC_data), 128'd0);
    check({tag, "_pend"}, 128'(b1.o_commit_pending), 128'd0);
    check({tag, "_done"}, 128'(b1.o_commit_done), 128'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b1.i_VIC_regaddr = 5'($urandom);
      b1.i_VIC_data    = 4'($urandom);
      b1.i_VIC_we      = 1'($urandom);
      b1.i_frame_sync  = 1'($urandom);
      b2.i_VIC_regaddr = 5'($urandom);
      b2.i_VIC_data    = 8'($urandom);
      b2.i_VIC_we      = 1'($urandom);
      b2.i_frame_sync  = 1'($urandom);
      tick();
    end
    all_zero1("reset");
    check("reset_buf2", 128'(b2.o_buffer), 128'd0);
    b1.i_VIC_regaddr = '0;
    b1.i_VIC_data    = '0;
    b1.i_VIC_we      = 1'b0;
    b1.i_frame_sync  = 1'b0;
    b2.i_VIC_regaddr = '0;
    b2.i_VIC_data    = '0;
    b2.i_VIC_we      = 1'b0;
    b2.i_frame_sync  = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // shadow write alone never reaches the active bank
    wr1(5'd3, 4'hA);
    b1.i_frame_sync = 1'b1;
    tick();
    b1.i_frame_sync = 1'b0;
    check("nocommit_buf", 128'(b1.o_buffer[15:12]), 128'h0);
    check("nocommit_done", 128'(b1.o_commit_done), 128'd0);
    rd1("rd_reg3", 5'd3, 4'hA);
    b1.i_VIC_regaddr = 5'd3;
    b1.i_VIC_data    = 4'h7;
    b1.i_VIC_we      = 1'b1;
    sb.push_back(128'(4'hA));
    tick();
    check("rd_during_wr", 128'(b1.o_VIC_data), sb.pop_front());
    b1.i_VIC_we = 1'b0;
    rd1("rd_after_wr", 5'd3, 4'h7);
    wr1(5'd3, 4'hA);

    // frame-synced commit
    wr1(5'd31, 4'b0011);
    check("sync_en", 128'(b1.o_enable), 128'd1);
    check("sync_pend_e0", 128'(b1.o_commit_pending), 128'd0);
    tick();
    check("sync_pend_e1", 128'(b1.o_commit_pending), 128'd1);
    rd1("rd_ctrl_pend", 5'd31, 4'b0011);
    check("sync_pend_e2", 128'(b1.o_commit_pending), 128'd1);
    tick();
    tick();
    check("sync_pend_e4", 128'(b1.o_commit_pending), 128'd1);
    check("sync_buf_pre", 128'(b1.o_buffer[15:12]), 128'h0);
    b1.i_frame_sync = 1'b1;
    tick();
    b1.i_frame_sync = 1'b0;
    check("sync_pend_s", 128'(b1.o_commit_pending), 128'd0);
    check("sync_done_s", 128'(b1.o_commit_done), 128'd0);
    check("sync_buf_s", 128'(b1.o_buffer[15:12]), 128'h0);
    tick();
    check("sync_buf_s1", 128'(b1.o_buffer[15:12]), 128'hA);
    check("sync_done_s1", 128'(b1.o_commit_done), 128'd1);
    tick();
    check("sync_done_s2", 128'(b1.o_commit_done), 128'd0);

    // immediate commit
    wr1(5'd0, 4'h9);
    wr1(5'd5, 4'hC);
    wr1(5'd31, 4'b0111);
    check("imm_pend_e0", 128'(b1.o_commit_pending), 128'd0);
    check("imm_done_e0", 128'(b1.o_commit_done), 128'd0);
    tick();
    check("imm_pend_e1", 128'(b1.o_commit_pending), 128'd0);
    check("imm_done_e1", 128'(b1.o_commit_done), 128'd0);
    check("imm_buf_e1", 128'(b1.o_buffer[23:20]), 128'h0);
    tick();
    check("imm_done_e2", 128'(b1.o_commit_done), 128'd1);
    check("imm_en", 128'(b1.o_enable), 128'd1);
    check("imm_pend_e2", 128'(b1.o_commit_pending), 128'd0);
    check("imm_buf_r5", 128'(b1.o_buffer[23:20]), 128'hC);
    check("imm_buf_r0", 128'(b1.o_buffer[3:0]), 128'h9);
    tick();
    check("imm_done_e3", 128'(b1.o_commit_done), 128'd0);

    // write in COPY cycle; second request ignored
    wr1(5'd31, 4'b0011);
    tick();
    check("cp_pend", 128'(b1.o_commit_pending), 128'd1);
    wr1(5'd31, 4'b0011);
    b1.i_frame_sync = 1'b1;
    tick();
    b1.i_frame_sync = 1'b0;
    wr1(5'd0, 4'h5);
    check("cp_done", 128'(b1.o_commit_done), 128'd1);
    check("cp_buf_r0", 128'(b1.o_buffer[3:0]), 128'h9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cp_no_requeue_pend", 128'(b1.o_commit_pending), 128'd0);
      check("cp_no_requeue_done", 128'(b1.o_commit_done), 128'd0);
    end
    check("cp_buf_hold", 128'(b1.o_buffer[3:0]), 128'h9);
    rd1("rd_shadow_r0", 5'd0, 4'h5);

    // reset during WAIT_SYNC
    wr1(5'd31, 4'b0011);
    tick();
    check("rst_pend_pre", 128'(b1.o_commit_pending), 128'd1);
    rd1("rd_ctrl_pre_rst", 5'd31, 4'b0011);
    rst = 1'b0;
    #1;
    all_zero1("midrst");
    tick();
    rst = 1'b1;
    b1.i_frame_sync = 1'b1;
    tick();
    b1.i_frame_sync = 1'b0;
    tick();
    check("rst_abandon_buf", 128'(b1.o_buffer), 128'd0);
    check("rst_abandon_done", 128'(b1.o_commit_done), 128'd0);
    rd1("rd_r0_cleared", 5'd0, 4'h0);

    // 8-bit, 16-register build
    wr2(5'd20, 8'hFF);
    rd2("rd2_addr20", 5'd20, 8'h00);
    rd2("rd2_alias4", 5'd4, 8'h00);
    wr2(5'd14, 8'hAB);
    wr2(5'd15, 8'h07);
    tick();
    tick();
    check("b2_buf_r14", 128'(b2.o_buffer[119:112]), 128'hAB);
    check("b2_done", 128'(b2.o_commit_done), 128'd1);
    check("b2_en", 128'(b2.o_enable), 128'd1);
    rd2("rd2_ctrl", 5'd15, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
